// File: rtl/uart_rx_packer_if.sv
// uart_rx_packer_if: output word handshake between the UART packer and its consumer
// Signals:
//   data  [DEPTH-1:0][7:0]  packed word, data[0] is the first byte received
//   count                   number of valid bytes in data
//   valid                   producer holds an untaken word
//   ready                   consumer takes the word when valid && ready
interface uart_rx_packer_if #(
    parameter int DEPTH = 4
);
    logic [DEPTH-1:0][7:0]        data;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         valid;
    logic                         ready;
    modport master (output data, count, valid, input ready);
    modport slave (input data, count, valid, output ready);
endinterface

// File: rtl/uart_rx_packer.sv
// uart_rx_packer: UART receiver (5..8 data bits, optional parity, 1/2 stop) packing DEPTH bytes per word
// Ports:
//   clk           system clock
//   arstn         synchronous active-low reset
//   rx_i          asynchronous serial line, idle high
//   out_if        master side of the word handshake (data, count, valid / ready)
//   frame_err_o   one-cycle pulse, a stop bit was sampled low
//   parity_err_o  one-cycle pulse, parity mismatch on an otherwise well-framed byte
//   overrun_o     one-cycle pulse, a finished word was dropped because the output was full
module uart_rx_packer #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int boadrate  = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 0
) (
    input  logic              clk,
    input  logic              arstn,
    input  logic              rx_i,
    uart_rx_packer_if.master  out_if,
    output logic              frame_err_o,
    output logic              parity_err_o,
    output logic              overrun_o
);
    localparam int DIV = (CLK_FREQ + boadrate / 2) / boadrate;
    localparam int CW  = $clog2(DIV);
    localparam int IW  = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int NW  = $clog2(DEPTH + 1);
    localparam int TW  = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

    state_e                 state_q;
    logic                   s1_q, s2_q, prev_q;
    logic [CW-1:0]          cnt_q;
    logic [2:0]             bit_q;
    logic [7:0]             byte_q;
    logic                   perr_q, ferr_q;
    logic [IW-1:0]          idx_q;
    logic [TW-1:0]          to_q;
    logic [DEPTH-1:0][7:0]  asm_q, data_q;
    logic [NW-1:0]          count_q;
    logic                   valid_q, frame_err_q, parity_err_q, overrun_q;

    logic                   fall, tick, commit, full, flush, push;
    logic [DEPTH-1:0][7:0]  word_d;

    always_comb begin
        word_d = asm_q;
        word_d[idx_q] = byte_q;
        fall = prev_q & ~s2_q;
        tick = cnt_q == '0;
        commit = state_q == STOP && !ferr_q && tick && s2_q && bit_q == 3'(STOP_BITS - 1) && !perr_q;
        full = commit && idx_q == IW'(DEPTH - 1);
        flush = TIMEOUT > 0 && state_q == IDLE && !fall && idx_q != '0 && tick && to_q == TW'(TIMEOUT - 1);
        push = full || flush;
    end

    // The bit counter free-runs at DIV cycles; every non-idle state samples on its wrap,
    // and in IDLE the same wrap paces the idle-timeout in whole bit periods.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_q      <= IDLE;
            s1_q         <= 1'b1;
            s2_q         <= 1'b1;
            prev_q       <= 1'b1;
            cnt_q        <= '0;
            bit_q        <= '0;
            byte_q       <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            idx_q        <= '0;
            to_q         <= '0;
            asm_q        <= '0;
            data_q       <= '0;
            count_q      <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            s1_q         <= rx_i;
            s2_q         <= s1_q;
            prev_q       <= s2_q;
            cnt_q        <= tick ? CW'(DIV - 1) : cnt_q - 1'b1;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            if (valid_q && out_if.ready) valid_q <= 1'b0;
            if (push) begin
                if (!valid_q || out_if.ready) begin
                    data_q  <= flush ? asm_q : word_d;
                    count_q <= flush ? NW'(idx_q) : NW'(DEPTH);
                    valid_q <= 1'b1;
                end else overrun_q <= 1'b1;
            end
            if (commit) begin
                asm_q <= full ? '0 : word_d;
                idx_q <= full ? '0 : idx_q + 1'b1;
            end
            if (flush) begin
                asm_q <= '0;
                idx_q <= '0;
            end
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        state_q <= START;
                        cnt_q   <= CW'(DIV / 2 - 1);
                        to_q    <= '0;
                        bit_q   <= '0;
                        byte_q  <= '0;
                        perr_q  <= 1'b0;
                    end else if (TIMEOUT > 0 && idx_q != '0 && tick) to_q <= flush ? '0 : to_q + 1'b1;
                end
                START: if (tick) state_q <= s2_q ? IDLE : DATA;
                DATA: begin
                    if (tick) begin
                        byte_q[bit_q] <= s2_q;
                        bit_q <= bit_q == 3'(DATA_BITS - 1) ? '0 : bit_q + 1'b1;
                        if (bit_q == 3'(DATA_BITS - 1)) state_q <= PARITY != 0 ? PAR : STOP;
                    end
                end
                PAR: begin
                    if (tick) begin
                        perr_q  <= (^byte_q ^ s2_q) != (PARITY == 1);
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    // A parity error is only reported once the stop bits are known good,
                    // so a frame with both faults raises frame_err alone.
                    if (ferr_q) begin
                        if (s2_q) begin
                            state_q <= IDLE;
                            ferr_q  <= 1'b0;
                            cnt_q   <= CW'(DIV - 1);
                        end
                    end else if (tick) begin
                        if (!s2_q) begin
                            frame_err_q <= 1'b1;
                            ferr_q      <= 1'b1;
                        end else if (bit_q == 3'(STOP_BITS - 1)) begin
                            state_q      <= IDLE;
                            parity_err_q <= perr_q;
                        end else bit_q <= bit_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_if.data  = data_q;
    assign out_if.count = count_q;
    assign out_if.valid = valid_q;
    assign frame_err_o  = frame_err_q;
    assign parity_err_o = parity_err_q;
    assign overrun_o    = overrun_q;
endmodule

// File: tb/tb_uart_rx_packer.sv
// tb_uart_rx_packer: directed bench for uart_rx_packer over four frame formats
// u0 8N1, u1 8E1, u2 8N1 with TIMEOUT=4, u3 7N2; all DEPTH=4 at 16 clocks per bit.
module tb_uart_rx_packer;
    localparam int DIV = 16;

    logic clk = 1'b0;
    logic arstn;
    logic [3:0] rx, rdy, vld, fe, pe, ov;
    logic [3:0][31:0] dat;
    logic [3:0][2:0] cnt;

    int nchk = 0;
    int nfail = 0;
    int nacc[4] = '{0, 0, 0, 0};
    int nfe[4] = '{0, 0, 0, 0};
    int npe[4] = '{0, 0, 0, 0};
    int nov[4] = '{0, 0, 0, 0};
    logic [31:0] cap_d[4];
    logic [2:0] cap_c[4];

    uart_rx_packer_if #(.DEPTH(4)) if0 ();
    uart_rx_packer_if #(.DEPTH(4)) if1 ();
    uart_rx_packer_if #(.DEPTH(4)) if2 ();
    uart_rx_packer_if #(.DEPTH(4)) if3 ();

    uart_rx_packer #(.CLK_FREQ(1600), .boadrate(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4), .TIMEOUT(0)) u0 (
        .clk(clk), .arstn(arstn), .rx_i(rx[0]), .out_if(if0), .frame_err_o(fe[0]), .parity_err_o(pe[0]), .overrun_o(ov[0]));
    uart_rx_packer #(.CLK_FREQ(1600), .boadrate(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DEPTH(4), .TIMEOUT(0)) u1 (
        .clk(clk), .arstn(arstn), .rx_i(rx[1]), .out_if(if1), .frame_err_o(fe[1]), .parity_err_o(pe[1]), .overrun_o(ov[1]));
    uart_rx_packer #(.CLK_FREQ(1600), .boadrate(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4), .TIMEOUT(4)) u2 (
        .clk(clk), .arstn(arstn), .rx_i(rx[2]), .out_if(if2), .frame_err_o(fe[2]), .parity_err_o(pe[2]), .overrun_o(ov[2]));
    uart_rx_packer #(.CLK_FREQ(1600), .boadrate(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .DEPTH(4), .TIMEOUT(0)) u3 (
        .clk(clk), .arstn(arstn), .rx_i(rx[3]), .out_if(if3), .frame_err_o(fe[3]), .parity_err_o(pe[3]), .overrun_o(ov[3]));

    assign vld = {if3.valid, if2.valid, if1.valid, if0.valid};
    assign dat = {if3.data, if2.data, if1.data, if0.data};
    assign cnt = {if3.count, if2.count, if1.count, if0.count};
    assign if0.ready = rdy[0];
    assign if1.ready = rdy[1];
    assign if2.ready = rdy[2];
    assign if3.ready = rdy[3];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (vld[i] && rdy[i]) begin
                nacc[i]++;
                cap_d[i] = dat[i];
                cap_c[i] = cnt[i];
            end
            nfe[i] += int'(fe[i]);
            npe[i] += int'(pe[i]);
            nov[i] += int'(ov[i]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_bits(input int u, input logic [15:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            rx[u] = f[i];
            cyc(DIV);
        end
    endtask

    task automatic send_byte(input int u, input logic [7:0] b, input int nb, input int par, input bit flip, input int nstop);
        logic [15:0] f;
        logic [7:0] m;
        int n;
        m = b & 8'((1 << nb) - 1);
        f = '0;
        for (int i = 0; i < nb; i++) f[1 + i] = m[i];
        n = 1 + nb;
        if (par != 0) begin
            f[n] = (^m) ^ (par == 1) ^ flip;
            n++;
        end
        for (int i = 0; i < nstop; i++) begin
            f[n] = 1'b1;
            n++;
        end
        send_bits(u, f, n);
    endtask

    task automatic send_word(input int u, input logic [31:0] w, input int nb, input int par, input int nstop);
        for (int k = 0; k < 4; k++) send_byte(u, w[8*k +: 8], nb, par, 1'b0, nstop);
    endtask

    task automatic wait_acc(input int u, input int base, input int lim);
        for (int i = 0; i < lim && nacc[u] == base; i++) cyc(1);
    endtask

    typedef struct {
        int u;
        int nb;
        int par;
        int nstop;
        logic [31:0] tx;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int b0, e0, u;
        vt[0] = '{0, 8, 0, 1, 32'hAA0FF055, 32'hAA0FF055};
        vt[1] = '{0, 8, 0, 1, 32'h00FF8001, 32'h00FF8001};
        vt[2] = '{1, 8, 2, 1, 32'h04030201, 32'h04030201};
        vt[3] = '{2, 8, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF};
        vt[4] = '{3, 7, 0, 2, 32'hFF807FC3, 32'h7F007F43};
        vt[5] = '{3, 7, 0, 2, 32'h55AA3C81, 32'h552A3C01};
        arstn = 1'b0;
        rx = '1;
        rdy = '1;
        cyc(3);
        chk("rst_valid", 64'(vld), 0);
        chk("rst_err", 64'({fe, pe, ov}), 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_data%0d", i), 64'(dat[i]), 0);
            chk($sformatf("rst_count%0d", i), 64'(cnt[i]), 0);
        end
        arstn = 1'b1;
        cyc(2 * DIV);

        for (int k = 0; k < 6; k++) begin
            u = vt[k].u;
            b0 = nacc[u];
            e0 = nfe[u] + npe[u] + nov[u];
            send_word(u, vt[k].tx, vt[k].nb, vt[k].par, vt[k].nstop);
            wait_acc(u, b0, 4 * DIV);
            chk($sformatf("vec%0d_words", k), 64'(nacc[u] - b0), 1);
            chk($sformatf("vec%0d_data", k), 64'(cap_d[u]), 64'(vt[k].exp));
            chk($sformatf("vec%0d_count", k), 64'(cap_c[u]), 4);
            chk($sformatf("vec%0d_errs", k), 64'(nfe[u] + npe[u] + nov[u] - e0), 0);
            cyc(DIV);
        end

        b0 = nacc[1];
        e0 = npe[1];
        send_byte(1, 8'hA5, 8, 2, 1'b1, 1);
        cyc(DIV);
        chk("par_err_pulses", 64'(npe[1] - e0), 1);
        chk("par_frame_errs", 64'(nfe[1]), 0);
        send_word(1, 32'h04030201, 8, 2, 1);
        wait_acc(1, b0, 4 * DIV);
        chk("par_words", 64'(nacc[1] - b0), 1);
        chk("par_data", 64'(cap_d[1]), 64'h04030201);
        cyc(DIV);

        b0 = nacc[0];
        e0 = nfe[0];
        send_bits(0, 16'h0078, 9);
        rx[0] = 1'b0;
        cyc(3 * DIV);
        rx[0] = 1'b1;
        cyc(2 * DIV);
        chk("frm_err_pulses", 64'(nfe[0] - e0), 1);
        chk("frm_no_word", 64'(nacc[0] - b0), 0);
        send_word(0, 32'h44332211, 8, 0, 1);
        wait_acc(0, b0, 4 * DIV);
        chk("frm_words", 64'(nacc[0] - b0), 1);
        chk("frm_data", 64'(cap_d[0]), 64'h44332211);
        cyc(DIV);

        b0 = nacc[0];
        e0 = nov[0];
        rdy[0] = 1'b0;
        send_word(0, 32'h04030201, 8, 0, 1);
        cyc(2);
        chk("bp_valid_held", 64'(vld[0]), 1);
        send_word(0, 32'h08070605, 8, 0, 1);
        cyc(2);
        chk("bp_overrun", 64'(nov[0] - e0), 1);
        chk("bp_valid_still", 64'(vld[0]), 1);
        chk("bp_data_kept", 64'(dat[0]), 64'h04030201);
        chk("bp_count_kept", 64'(cnt[0]), 4);
        chk("bp_not_taken", 64'(nacc[0] - b0), 0);
        rdy[0] = 1'b1;
        cyc(1);
        chk("bp_valid_drop", 64'(vld[0]), 0);
        chk("bp_taken", 64'(nacc[0] - b0), 1);
        chk("bp_taken_data", 64'(cap_d[0]), 64'h04030201);
        cyc(DIV);

        b0 = nacc[2];
        send_byte(2, 8'h12, 8, 0, 1'b0, 1);
        send_byte(2, 8'h34, 8, 0, 1'b0, 1);
        cyc(3 * DIV);
        chk("tmo_not_early", 64'(nacc[2] - b0), 0);
        wait_acc(2, b0, 4 * DIV);
        chk("tmo_words", 64'(nacc[2] - b0), 1);
        chk("tmo_count", 64'(cap_c[2]), 2);
        chk("tmo_data", 64'(cap_d[2]), 64'h00003412);
        cyc(DIV);

        rdy[0] = 1'b0;
        send_word(0, 32'hA0B0C0D0, 8, 0, 1);
        send_byte(0, 8'h5A, 8, 0, 1'b0, 1);
        send_bits(0, 16'h000A, 4);
        arstn = 1'b0;
        cyc(2);
        chk("mid_rst_valid", 64'(vld[0]), 0);
        chk("mid_rst_data", 64'(dat[0]), 0);
        chk("mid_rst_count", 64'(cnt[0]), 0);
        chk("mid_rst_err", 64'({fe[0], pe[0], ov[0]}), 0);
        rx[0] = 1'b1;
        cyc(2);
        arstn = 1'b1;
        rdy[0] = 1'b1;
        cyc(2 * DIV);
        b0 = nacc[0];
        e0 = nfe[0] + npe[0] + nov[0];
        rx[0] = 1'b0;
        cyc(5);
        rx[0] = 1'b1;
        cyc(3 * DIV);
        chk("glitch_no_word", 64'(nacc[0] - b0), 0);
        chk("glitch_no_err", 64'(nfe[0] + npe[0] + nov[0] - e0), 0);
        send_word(0, 32'hD4C3B2A1, 8, 0, 1);
        wait_acc(0, b0, 4 * DIV);
        chk("post_rst_words", 64'(nacc[0] - b0), 1);
        chk("post_rst_data", 64'(cap_d[0]), 64'hD4C3B2A1);
        chk("post_rst_count", 64'(cap_c[0]), 4);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/uart_rx_packer.md
# uart_rx_packer

Parametrised UART receiver with configurable frame format (data bits, parity, stop bits). It assembles `DEPTH` received bytes into one output word, offered under a valid/ready handshake. It replaces the fixed 8N1 byte-packing receiver at the serial input of the FFT datapath. Beyond the previous generation it adds start-bit glitch rejection, parity and framing error reporting, a one-word output buffer with overrun detection, and an idle-timeout flush of partial words.

## Interface
- `CLK_FREQ`, 50_000_000: clk frequency, Hz
- `boadrate`, 115200: line rate, baud
- `DATA_BITS`, 8: data bits per frame, legal 5..8
- `PARITY`, 0: 0 none, 1 odd, 2 even
- `STOP_BITS`, 1: 1 or 2
- `DEPTH`, 4: bytes per output word, ≥1
- `TIMEOUT`, 0: idle bit-times before a partial word is flushed; 0 disables flushing
- `clk  in  1`: system clock
- `arstn  in  1`: reset; synchronous, active-low
- `rx  in  1`: asynchronous serial line, idle high
- `data  out  [DEPTH-1:0][7:0]`: packed word; `data[0]` holds the first byte received
- `count  out  $clog2(DEPTH+1)`: number of valid bytes in `data` (DEPTH, or fewer on a flush)
- `valid  out  1`: `data`/`count` hold an untaken word
- `ready  in  1`: consumer accepts the word when `valid && ready`
- `frame_err  out  1`: one-cycle pulse, stop bit sampled 0
- `parity_err  out  1`: one-cycle pulse, parity mismatch
- `overrun  out  1`: one-cycle pulse, completed word dropped because the output was full

## Operation
- `rx` passes through a 2-flop synchroniser. All logic uses the synchronised value `rxs`.
- Bit period: `DIV = (CLK_FREQ + boadrate/2) / boadrate`, so 434 at the defaults. The bit counter is sized `$clog2(DIV)`.
- State machine: IDLE → START → DATA → (PARITY if `PARITY != 0`) → STOP → IDLE.
- **IDLE:** a falling edge on `rxs` loads the bit counter and enters START.
- **START:** `rxs` is sampled at DIV/2 cycles.
  - If high: glitch; return to IDLE with no output.
  - If low: enter DATA.
- **Sampling:** every later sample is taken DIV cycles after the previous one, i.e. at bit centre.
- **DATA:** `DATA_BITS` samples, LSB first. Bits [7:DATA_BITS] of the byte are 0.
- **PARITY:** one sample, XOR-checked against the data bits.
  - Odd parity: the XOR of data and parity is 1.
  - Even parity: the XOR of data and parity is 0.
- **STOP:** `STOP_BITS` samples.
  - All samples high: the byte is good and the machine returns to IDLE at the last stop-bit centre, not at the end of the bit.
  - Any sample low: `frame_err`, then stay in STOP until `rxs` is high before returning to IDLE.
- **Error byte handling:** on a parity or framing error the byte is discarded, the byte index is unchanged, and only the error pulse is emitted. If both errors occur in one frame, only `frame_err` pulses.
- **Byte commit:** a good byte is written to the assembly register at slot `idx`, then `idx` increments.
  - When `idx` reaches DEPTH the word is complete.
  - If the output register is empty, or is being taken in the same cycle (`valid && ready`), the word is transferred: `count = DEPTH`, `valid = 1`.
  - Otherwise `overrun` pulses, the new word is dropped, and the output register is unchanged.
  - In every case `idx` returns to 0.
- **Timeout** (`TIMEOUT > 0`): an idle counter counts full bit periods while in IDLE with `idx > 0`. It clears whenever a start edge is detected.
  - At `TIMEOUT` bit periods the partial word is transferred under the same rules as a full word, with `count = idx` and unfilled slots set to 0.
  - `idx` returns to 0 after the transfer.
- **Handshake:** `valid` stays high with `data`/`count` stable until `valid && ready`, then falls on the next cycle unless a new word loads in that same cycle.

## Timing
- **Reset:** while `arstn` is low at a rising edge of `clk`:
  - `data`, `count`, `valid`, `frame_err`, `parity_err` and `overrun` are 0;
  - the FSM is in IDLE, and `idx` and the idle counter are 0;
  - the synchroniser flops are set to 1.
  - A reset mid-frame abandons the current byte and any partial word.
- **Start detect:** 2 cycles of synchroniser delay plus 1 cycle for edge detection after `rx` falls.
- **Word output:** `valid` rises 1 cycle after the centre-sample of the last stop bit of the completing byte.
- **Error pulses:** `frame_err` and `parity_err` assert 1 cycle after the offending sample, for exactly 1 cycle.
- **Overrun:** `overrun` asserts in the same cycle a dropped word would have loaded into the output register.
- **Back-to-back frames:** a start edge immediately after the stop-bit centre is accepted, so frames with zero extra idle time are received.

## Test plan
- **Basic 8N1 packing** (defaults, `ready = 1`): bytes 0x55, 0xF0, 0x0F, 0xAA → one `valid` pulse; `data[0..3] = 55, F0, 0F, AA`; `count = 4`; no error pulses.
- **Parity error** (`PARITY = 2`): byte 0xA5 sent with parity bit 1 → `parity_err` pulse and the byte is dropped; then 4 correctly framed bytes 01..04 → `data[0..3] = 01..04`.
- **Framing error:** stop bit held 0 for 3 bit-times → `frame_err` pulse, no `valid`; then 4 good bytes → normal word.
- **Backpressure:** `ready = 0`, send 8 bytes → the first word is held with `valid = 1`, then `overrun` pulses once at byte 8 and `data` still holds bytes 1-4; raise `ready` → `valid` drops the next cycle.
- **Timeout flush** (`TIMEOUT = 4`): send 0x12, 0x34, then idle → after 4 bit-times `valid` with `count = 2`, `data[0] = 12`, `data[1] = 34`, `data[3:2] = 0`.
- **Glitch and reset:**
  - Pulse `rx` low for 100 cycles → no reception.
  - Assert `arstn` low mid-byte → all outputs 0.
  - After release, a clean 4-byte burst is received correctly.
  - Repeat the basic packing scenario with `DATA_BITS = 7` and `STOP_BITS = 2`; bit 7 of each byte must be 0.
